register_file: RTL

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/register_file.sv | 82 ++++++++
 1 files changed

// File: rtl/register_file.sv
// Multi-ported register file: one write port, two combinational read ports,
// optional hardwired zero register, optional write-to-read forwarding and a saturating write counter.
module register_file #(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 32,
  parameter int               ADDR_W    = $clog2(DEPTH),
  parameter int               ZERO_REG  = 1,
  parameter int               BYPASS    = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [WIDTH-1:0]  rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]  rd_data_b,
  output logic [15:0]       wr_count
);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [15:0]      count_q;
  logic             is_zero_wr;
  logic             commit;
  logic             fwd_ok;

  // A write to the hardwired zero register is neither stored nor counted.
  assign is_zero_wr = (ZERO_REG != 0) && (wr_addr == '0);
  assign commit     = wr_en && !clear && !is_zero_wr;
  assign fwd_ok     = (BYPASS != 0) && rst_n && commit;

  // NOTE: the storage array is reset like any other flop because reset must
  // discard every register immediately; this rules out mapping it onto a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block evaluation order.
        regs[i] <= RESET_VAL;
      end
      count_q <= '0;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= RESET_VAL;
      end
      count_q <= '0;
    end else if (commit) begin
      regs[wr_addr] <= wr_data;
      if (count_q != 16'hFFFF) begin
        count_q <= count_q + 16'd1;
      end
    end
  end

  assign wr_count = count_q;

  // NOTE: each read output gets its stored value as a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    rd_data_a = regs[rd_addr_a];
    if (fwd_ok && (rd_addr_a == wr_addr)) begin
      rd_data_a = wr_data;
    end
    if ((ZERO_REG != 0) && (rd_addr_a == '0)) begin
      rd_data_a = '0;
    end
  end

  always_comb begin
    rd_data_b = regs[rd_addr_b];
    if (fwd_ok && (rd_addr_b == wr_addr)) begin
      rd_data_b = wr_data;
    end
    if ((ZERO_REG != 0) && (rd_addr_b == '0)) begin
      rd_data_b = '0;
    end
  end

endmodule
